// File: rtl/det_pkg.sv
// Shared detection-path types, default widths and the signed clamp helper.
package det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEARN = 2'd1,
        RUN   = 2'd2
    } state_e;

    localparam int DEF_NUM_LANES = 16;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_NOISE_W   = 16;
    localparam int DEF_AVG_LOG2  = 4;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_sdata(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/bg_lane_sub.sv
// One lane of the noise subtractor: sample minus noise level, clamped or wrapped to DATA_W.
// Purely combinational; no flow control of its own.
module bg_lane_sub
    import det_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NOISE_W  = DEF_NOISE_W,
    parameter bit SATURATE = 1'b1
) (
    input  logic [DATA_W-1:0]  data_i,
    input  logic [NOISE_W-1:0] noise_i,
    output logic [DATA_W-1:0]  res_o
);

    localparam int XW = NOISE_W + 1;

    logic signed [XW-1:0]     data_x;
    logic signed [XW-1:0]     noise_x;
    logic signed [XW-1:0]     diff;
    logic        [DATA_W-1:0] sat_res;

    always_comb begin
        data_x  = XW'($signed(data_i));
        noise_x = XW'($signed(noise_i));
        diff    = data_x - noise_x;
        sat_res = DATA_W'(sat_sdata(64'(diff), DATA_W));
        res_o   = SATURATE ? sat_res : diff[DATA_W-1:0];
    end

endmodule

// File: rtl/bg_noise_remover.sv
// Per-lane background removal: learns noise as the mean of 2**AVG_LOG2 beats or takes a host value.
// One-cycle registered output; in_ready follows out_ready except in LEARN, where beats are always taken.
module bg_noise_remover
    import det_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NOISE_W   = DEF_NOISE_W,
    parameter int AVG_LOG2  = DEF_AVG_LOG2,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_LANES*DATA_W-1:0]  in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_LANES*DATA_W-1:0]  out_data,
    input  logic                         learn_start,
    output logic                         learn_done,
    input  logic                         noise_wr,
    input  logic [NUM_LANES*NOISE_W-1:0] noise_in,
    output logic [NUM_LANES*NOISE_W-1:0] noise_out
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int WIN   = 2 ** AVG_LOG2;

    state_e                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d, cnt_base;
    logic signed [ACC_W-1:0]       acc_q [NUM_LANES];
    logic signed [ACC_W-1:0]       acc_d [NUM_LANES];
    logic signed [ACC_W-1:0]       lane_sum [NUM_LANES];
    logic signed [ACC_W-1:0]       lane_avg [NUM_LANES];
    logic signed [ACC_W-1:0]       samp_x [NUM_LANES];
    logic signed [DATA_W-1:0]      samp [NUM_LANES];
    logic [NOISE_W-1:0]            noise_q [NUM_LANES];
    logic [NOISE_W-1:0]            noise_d [NUM_LANES];
    logic                          out_valid_q, out_valid_d;
    logic [NUM_LANES*DATA_W-1:0]   out_data_q, out_data_d, diff_all;
    logic                          learn_done_q, learn_done_d;
    logic                          accept, learning, win_done;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign samp[g] = in_data[DATA_W*g +: DATA_W];
        assign noise_out[NOISE_W*g +: NOISE_W] = noise_q[g];

        bg_lane_sub #(
            .DATA_W   (DATA_W),
            .NOISE_W  (NOISE_W),
            .SATURATE (SATURATE)
        ) u_sub (
            .data_i  (in_data[DATA_W*g +: DATA_W]),
            .noise_i (noise_q[g]),
            .res_o   (diff_all[DATA_W*g +: DATA_W])
        );
    end

    // learn_start restarts the window in the same cycle, so the beat taken with it is sample 0.
    always_comb begin
        in_ready = (state_q == LEARN) | out_ready | ~out_valid_q;
        accept   = in_valid & in_ready;
        learning = (state_q == LEARN) | learn_start;
        cnt_base = learn_start ? '0 : cnt_q;
        win_done = accept & learning & (cnt_base == CNT_W'(WIN - 1));
        for (int i = 0; i < NUM_LANES; i++) begin
            samp_x[i]   = ACC_W'(samp[i]);
            lane_sum[i] = (learn_start ? '0 : acc_q[i]) + samp_x[i];
            lane_avg[i] = lane_sum[i] >>> AVG_LOG2;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        noise_d      = noise_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        learn_done_d = 1'b0;

        if (learning) begin
            // A beat already in the output register still drains while learning.
            if (out_ready) begin
                out_valid_d = 1'b0;
            end
            state_d = LEARN;
            cnt_d   = cnt_base;
            if (learn_start) begin
                for (int i = 0; i < NUM_LANES; i++) acc_d[i] = '0;
            end
            if (accept) begin
                cnt_d = cnt_base + 1'b1;
                for (int i = 0; i < NUM_LANES; i++) acc_d[i] = lane_sum[i];
                if (win_done) begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        noise_d[i] = NOISE_W'(lane_avg[i]);
                        acc_d[i]   = '0;
                    end
                    cnt_d        = '0;
                    state_d      = RUN;
                    learn_done_d = 1'b1;
                end
            end
        end else begin
            if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = diff_all;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
            if (noise_wr) begin
                for (int i = 0; i < NUM_LANES; i++) noise_d[i] = noise_in[NOISE_W*i +: NOISE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            learn_done_q <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                acc_q[i]   <= '0;
                noise_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            learn_done_q <= learn_done_d;
            acc_q        <= acc_d;
            noise_q      <= noise_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign learn_done = learn_done_q;

endmodule

// File: tb/tb_bg_noise_remover.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_bg_noise_remover;

    localparam int NL = 16;
    localparam int DW = 8;
    localparam int NW = 16;

    typedef struct packed {
        logic [NL*DW-1:0] sat;
        logic [NL*DW-1:0] wrp;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic             learn_start = 1'b0;
    logic             noise_wr = 1'b0;
    logic [NL*DW-1:0] in_data = '0;
    logic [NL*NW-1:0] noise_in = '0;

    logic             in_ready, out_valid, learn_done;
    logic [NL*DW-1:0] out_data;
    logic [NL*NW-1:0] noise_out;
    logic             w_in_ready, w_out_valid, w_learn_done;
    logic [NL*DW-1:0] w_out_data;
    logic [NL*NW-1:0] w_noise_out;

    always #5 clk = ~clk;

    bg_noise_remover #(.SATURATE(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .learn_start(learn_start), .learn_done(learn_done),
        .noise_wr(noise_wr), .noise_in(noise_in), .noise_out(noise_out)
    );

    bg_noise_remover #(.SATURATE(1'b0)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
        .learn_start(learn_start), .learn_done(w_learn_done),
        .noise_wr(noise_wr), .noise_in(noise_in), .noise_out(w_noise_out)
    );

    int   n_chk = 0;
    int   n_pass = 0;
    int   done_cnt = 0;
    bit   rand_rdy = 1'b0;
    exp_t exp_q[$];

    int   m_noise [NL];
    int   m_acc [NL];
    int   m_cnt = 0;
    bit   m_learning = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [NL*DW-1:0] mk_data(input int l0, input int l1, input int rest);
        logic [NL*DW-1:0] r;
        for (int i = 0; i < NL; i++) r[DW*i +: DW] = DW'((i == 0) ? l0 : (i == 1) ? l1 : rest);
        return r;
    endfunction

    function automatic logic [NL*NW-1:0] mk_nz(input int l0, input int l1, input int rest);
        logic [NL*NW-1:0] r;
        for (int i = 0; i < NL; i++) r[NW*i +: NW] = NW'((i == 0) ? l0 : (i == 1) ? l1 : rest);
        return r;
    endfunction

    function automatic logic [NL*NW-1:0] pack_noise();
        logic [NL*NW-1:0] r;
        for (int i = 0; i < NL; i++) r[NW*i +: NW] = NW'(m_noise[i]);
        return r;
    endfunction

    function automatic exp_t model_out(input logic [NL*DW-1:0] d);
        exp_t r;
        int   s;
        int   x;
        for (int i = 0; i < NL; i++) begin
            s = $signed(d[DW*i +: DW]);
            x = s - m_noise[i];
            r.wrp[DW*i +: DW] = x[DW-1:0];
            if (x > 127) x = 127;
            if (x < -128) x = -128;
            r.sat[DW*i +: DW] = x[DW-1:0];
        end
        return r;
    endfunction

    task automatic send_beat(input logic [NL*DW-1:0] d, input bit ls);
        int t;
        @(negedge clk);
        in_valid    = 1'b1;
        in_data     = d;
        learn_start = ls;
        t = 0;
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_chk++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
            in_valid    = 1'b0;
            learn_start = 1'b0;
            return;
        end
        if (ls) begin
            m_learning = 1'b1;
            m_cnt = 0;
            for (int i = 0; i < NL; i++) m_acc[i] = 0;
        end
        if (m_learning) begin
            for (int i = 0; i < NL; i++) m_acc[i] += int'($signed(d[DW*i +: DW]));
            m_cnt++;
            if (m_cnt == 16) begin
                for (int i = 0; i < NL; i++) m_noise[i] = m_acc[i] >>> 4;
                m_learning = 1'b0;
            end
        end else begin
            exp_q.push_back(model_out(d));
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        learn_start = 1'b0;
    endtask

    task automatic write_noise(input logic [NL*NW-1:0] nz);
        @(negedge clk);
        noise_wr = 1'b1;
        noise_in = nz;
        @(posedge clk);
        #1;
        noise_wr = 1'b0;
        if (!m_learning) begin
            for (int i = 0; i < NL; i++) m_noise[i] = int'($signed(nz[NW*i +: NW]));
        end
    endtask

    task automatic pulse_learn(input bit with_wr, input logic [NL*NW-1:0] nz);
        @(negedge clk);
        learn_start = 1'b1;
        noise_wr    = with_wr;
        noise_in    = nz;
        @(posedge clk);
        #1;
        learn_start = 1'b0;
        noise_wr    = 1'b0;
        m_learning  = 1'b1;
        m_cnt       = 0;
        for (int i = 0; i < NL; i++) m_acc[i] = 0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin : monitor
        logic             held_v;
        logic [NL*DW-1:0] held;
        exp_t             e;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v = 1'b0;
                continue;
            end
            if (learn_done) done_cnt++;
            if (held_v) begin
                chk("stall_valid", 256'(out_valid), 256'(1'b1));
                chk("stall_data", 256'(out_data), 256'(held));
            end
            if (out_valid && out_ready) begin
                held_v = 1'b0;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_out: got %0h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_sat", 256'(out_data), 256'(e.sat));
                    chk("out_wrap_valid", 256'(w_out_valid), 256'(1'b1));
                    chk("out_wrap", 256'(w_out_data), 256'(e.wrp));
                end
            end else if (out_valid) begin
                held_v = 1'b1;
                held   = out_data;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin : stim
        int d0;
        logic [NL*DW-1:0] rd;
        logic [NL*NW-1:0] nz;
        for (int i = 0; i < NL; i++) begin
            m_noise[i] = 0;
            m_acc[i]   = 0;
        end

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
        chk("rst_out_data", 256'(out_data), 256'(0));
        chk("rst_learn_done", 256'(learn_done), 256'(1'b0));
        chk("rst_noise_out", noise_out, 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(1'b1));
        chk("rst_wrap_noise", w_noise_out, 256'(0));
        chk("rst_wrap_in_ready", 256'(w_in_ready), 256'(1'b1));
        chk("rst_wrap_done", 256'(w_learn_done), 256'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        send_beat({NL{8'h05}}, 1'b0);
        chk("idle_latency", 256'(out_valid), 256'(1'b1));
        chk("idle_pass", 256'(out_data), 256'({NL{8'h05}}));

        write_noise(mk_nz(3, 3, 3));
        send_beat({NL{8'h05}}, 1'b0);
        chk("sub3", 256'(out_data), 256'({NL{8'h02}}));
        send_beat({NL{8'h80}}, 1'b0);
        chk("neg_sat", 256'(out_data), 256'({NL{8'h80}}));
        chk("neg_wrap", 256'(w_out_data), 256'({NL{8'h7D}}));

        pulse_learn(1'b0, '0);
        d0 = done_cnt;
        for (int b = 0; b < 15; b++) send_beat(mk_data(10, -3, 0), 1'b0);
        @(negedge clk);
        chk("learn_not_early", 256'(done_cnt), 256'(d0));
        send_beat(mk_data(10, -3, 0), 1'b0);
        @(negedge clk);
        #1;
        chk("learn_done", 256'(done_cnt), 256'(d0 + 1));
        chk("learn_noise", noise_out, mk_nz(10, -3, 0));
        @(negedge clk);
        #1;
        chk("learn_done_pulse", 256'(done_cnt), 256'(d0 + 1));
        send_beat(mk_data(20, 0, 0), 1'b0);
        chk("post_learn", 256'(out_data), 256'(mk_data(10, 3, 0)));

        write_noise(mk_nz(16'hFF00, 16'hFF00, 16'hFF00));
        send_beat({NL{8'h7F}}, 1'b0);
        chk("pos_sat", 256'(out_data), 256'({NL{8'h7F}}));
        write_noise(mk_nz(16'h0100, 16'h0100, 16'h0100));
        send_beat({NL{8'h80}}, 1'b0);
        chk("neg_sat_big", 256'(out_data), 256'({NL{8'h80}}));
        chk("neg_wrap_big", 256'(w_out_data), 256'({NL{8'h80}}));

        for (int i = 0; i < NL; i++) nz[NW*i +: NW] = NW'(i * 20 - 150);
        write_noise(nz);
        rand_rdy = 1'b1;
        for (int b = 0; b < 200; b++) begin
            for (int i = 0; i < NL; i++) rd[DW*i +: DW] = DW'($urandom);
            send_beat(rd, 1'b0);
        end
        rand_rdy = 1'b0;
        drain();

        pulse_learn(1'b1, mk_nz(16'h1234, 16'h1234, 16'h1234));
        chk("wr_vs_learn", noise_out, pack_noise());
        for (int b = 0; b < 7; b++) send_beat({NL{8'd100}}, 1'b0);
        d0 = done_cnt;
        send_beat({NL{8'hF9}}, 1'b1);
        for (int b = 0; b < 14; b++) send_beat({NL{8'hF9}}, 1'b0);
        @(negedge clk);
        chk("restart_not_early", 256'(done_cnt), 256'(d0));
        send_beat({NL{8'hF9}}, 1'b0);
        @(negedge clk);
        #1;
        chk("restart_done", 256'(done_cnt), 256'(d0 + 1));
        chk("restart_noise", noise_out, mk_nz(16'hFFF9, 16'hFFF9, 16'hFFF9));
        drain();

        pulse_learn(1'b0, '0);
        for (int b = 0; b < 5; b++) send_beat({NL{8'h33}}, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midlearn_rst_noise", noise_out, 256'(0));
        chk("midlearn_rst_valid", 256'(out_valid), 256'(1'b0));
        for (int i = 0; i < NL; i++) m_noise[i] = 0;
        m_learning = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_beat({NL{8'h05}}, 1'b0);
        chk("post_rst_run", 256'(out_data), 256'({NL{8'h05}}));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
